mem_arbiter: RTL



---
 rtl/mips_bus_pkg.sv | 24 ++
 rtl/mem_arbiter.sv | 114 +++++++++++
 2 files changed

// File: rtl/mips_bus_pkg.sv
// Shared types and default widths for the MIPS core memory bus.
// Used by the IF/DM memory arbiter and anything else that sits on the core-to-RAM path.
package mips_bus_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int MEM_LAT_DEF = 1;

    // Latency counter width; covers the full 1..15 RAM latency range.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE,
        IF,
        DM
    } arb_owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data memory, DM has priority.
// Each access runs grant -> fixed-latency wait -> one-cycle ack, then returns to idle.
module mem_arbiter
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ack,
    output logic                if_stall,

    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_be,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_ack,
    output logic                dm_stall,

    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    arb_state_t       state_q;
    arb_owner_t       owner_q;
    logic [CNT_W-1:0] cnt_q;

    assign if_stall = if_req & ~if_ack;
    assign dm_stall = dm_req & ~dm_ack;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= NONE;
            cnt_q     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            // mem_en and the acks are single-cycle pulses; the rest of the command holds.
            mem_en <= 1'b0;
            if_ack <= 1'b0;
            dm_ack <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (dm_req) begin
                        owner_q   <= DM;
                        mem_en    <= 1'b1;
                        mem_we    <= dm_we;
                        mem_be    <= dm_be;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        cnt_q     <= CNT_W'(MEM_LAT);
                        state_q   <= WAIT;
                    end else if (if_req) begin
                        owner_q  <= IF;
                        mem_en   <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_be   <= '0;
                        mem_addr <= if_addr;
                        cnt_q    <= CNT_W'(MEM_LAT);
                        state_q  <= WAIT;
                    end
                end

                WAIT: begin
                    if (cnt_q == '0) begin
                        if (owner_q == DM) begin
                            dm_rdata <= mem_rdata;
                            dm_ack   <= 1'b1;
                        end else if (owner_q == IF) begin
                            if_rdata <= mem_rdata;
                            if_ack   <= 1'b1;
                        end
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                // Requests are ignored here so a still-held request cannot re-issue.
                RESP: begin
                    owner_q <= NONE;
                    state_q <= IDLE;
                end

                default: begin
                    owner_q <= NONE;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
